// File: rtl/bitwise_unit_seq.sv
// Clocked bitwise unit: opcode-selected logic ops in one cycle; iterative shift/rotate, one bit per clock.
// Optional registered parity output when BITWISE_UNIT_PARITY_EN is defined.
module bitwise_unit_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             done,
`ifdef BITWISE_UNIT_PARITY_EN
  output logic             parity,
`endif
  output logic             zero
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       sop_q, sop_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] step_res;
  logic             is_shift;

  // Single-cycle result; shift ops land here only when shamt is zero.
  always_comb begin
    logic_res = '0;
    unique case (op)
      4'd0:  logic_res = a & b;
      4'd1:  logic_res = a | b;
      4'd2:  logic_res = a ^ b;
      4'd3:  logic_res = ~(a & b);
      4'd4:  logic_res = ~(a | b);
      4'd5:  logic_res = ~(a ^ b);
      4'd6:  logic_res = ~a;
      4'd7:  logic_res = b;
      4'd8, 4'd9, 4'd10, 4'd11: logic_res = a;
      default: logic_res = '0;
    endcase
  end

  always_comb begin
    step_res = x_q;
    unique case (sop_q)
      2'd0: step_res = {x_q[WIDTH-2:0], x_q[WIDTH-1]};
      2'd1: step_res = {x_q[0], x_q[WIDTH-1:1]};
      2'd2: step_res = {x_q[WIDTH-2:0], 1'b0};
      2'd3: step_res = {1'b0, x_q[WIDTH-1:1]};
      default: step_res = x_q;
    endcase
  end

  assign is_shift = (op[3:2] == 2'b10) && (shamt != '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      x_q     <= '0;
      cnt_q   <= '0;
      sop_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      sop_q   <= sop_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    sop_d   = sop_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_shift) begin
            x_d     = a;
            cnt_d   = shamt;
            sop_d   = op[1:0];
            state_d = StShift;
          end else begin
            x_d    = logic_res;
            done_d = 1'b1;
          end
        end
      end
      StShift: begin
        x_d   = step_res;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    x    = x_q;
    busy = (state_q == StShift);
    done = done_q;
    zero = (x_q == '0);
  end

`ifdef BITWISE_UNIT_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^x_d;
    end
  end

  assign parity = parity_q;
`endif

endmodule
